vector_mul_pipe: RTL and testbench
==================================

Name: vector_mul_pipe

Overview:
- Parametrised, fully pipelined fixed-point vector multiplier.
- Successor to the fixed 3-lane vector-by-scalar multiplier: lane count, word width, fraction bits and latency are all generic.
- Adds a per-transaction mode (vector x scalar, or element-wise vector x vector) and a valid/ready handshake with backpressure.
- Sits between ray/geometry stages (direction scaling, normal shading); whole transactions stream through it without loss.

Parameters:
- LANES, 3, number of vector elements.
- W, 32, element and scalar width; signed two's complement.
- FRAC, 16, fraction bits (Q(W-FRAC).FRAC); legal range 0..W-1.
- LAT, 4, pipeline latency in cycles from accept to out_valid; legal range 2..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block can accept this cycle.
- in_mode  in  1  0 = r_i = v_i*b_0 (scalar); 1 = r_i = v_i*b_i (element-wise).
- v  in  LANES*W  vector operand; lane i at [W*i +: W].
- b  in  LANES*W  second operand; in mode 0 only lane 0 is used, the upper lanes are ignored.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- r  out  LANES*W  result; lane i at [W*i +: W].
- overflow  out  LANES  per-lane flag: the full product did not fit in W bits. Qualified by out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all stage valids 0, out_valid 0, r 0, overflow 0. in_ready is combinational and reads 1 after reset.
- A transaction is accepted on a cycle with in_valid && in_ready. It is delivered on a cycle with out_valid && out_ready.
- Pipeline: LAT register stages, stall-all.
  - Stall = out_valid && !out_ready.
  - While stalled, every stage holds its data and valid.
  - in_ready = !stall.
  - Bubbles are not compressed: a stall freezes the whole pipe.
- Latency: with no stall, a transaction accepted at cycle t shows out_valid at cycle t+LAT.
- Throughput: one transaction per cycle with no stall.
- Ordering: results leave in acceptance order. No transaction is dropped or duplicated.
- Arithmetic, per lane:
  - p = signed(v_i) * signed(operand), full 2W-bit product.
  - q = p >>> FRAC, arithmetic shift, i.e. truncation toward negative infinity.
  - r_i = q[W-1:0].
  - overflow_i = 1 when q lies outside the signed W-bit range.
- in_mode is captured with the operands. Mixed modes back-to-back are legal with no bubble.
- out_valid && !out_ready: r, overflow and out_valid stay stable until the handshake completes (AXI-style hold).
- in_valid while in_ready = 0: no accept. The source must hold its data (upstream rule); the block does not latch it.
- rst asserted mid-stream: all in-flight transactions are discarded immediately. After release the block is empty and in_ready = 1.
- LANES = 1: mode 0 and mode 1 are identical.
- FRAC = 0: plain integer multiply, low W bits kept.

Optional Feature:
- Macro: VMUL_SATURATE_EN.
- Defined: a lane with overflow_i = 1 outputs the clamped value instead of wrapped bits. Positive overflow gives 0x7FFF..F; negative overflow gives 0x8000..0. The overflow flag is still reported. Latency is unchanged.
- Undefined: the result wraps (low W bits of q) and overflow is a status flag only.

Test Plan (defaults, Q16.16):
- Mode 0: v = {0x00020000, 0x00018000, 0xFFFF0000}, b_0 = 0x00008000 (0.5) -> r = {0x00010000, 0x0000C000, 0xFFFF8000}; out_valid exactly 4 cycles after accept; overflow = 0.
- Mode 1: v = {0x00020000, 0x00030000, 0x00010000}, b = {0x00018000, 0xFFFF0000, 0x00000000} -> r = {0x00030000, 0xFFFD0000, 0x00000000}.
- Truncation: v_0 = 0xFFFFFFFF, b_0 = 0x00008000 -> r_0 = 0xFFFFFFFF (floor of -0.5 LSB); v_0 = 0x00000001 with the same b_0 -> r_0 = 0x00000000.
- Overflow: v_0 = 0x7FFF0000, b_0 = 0x00020000 -> overflow[0] = 1; r_0 = 0xFFFE0000 without the macro, 0x7FFFFFFF with VMUL_SATURATE_EN.
- Backpressure: 20 back-to-back transactions with out_ready low on cycles 6-15 -> exactly 20 results, in order, values unchanged; r held stable while stalled; in_ready = 0 exactly on stalled cycles.
- Reset mid-stream: assert rst with 3 transactions in flight -> out_valid, r and overflow go to 0 asynchronously; after release no stale result appears; the next transaction has latency 4.

Source files
------------

// File: rtl/vector_mul_pipe_if.sv
// Streaming handshake bundle for vector_mul_pipe: operand side (in_*/v/b)
// and result side (out_*/r/overflow). The slave modport is the multiplier's view.
interface vector_mul_pipe_if #(
    parameter int LANES = 3,
    parameter int W     = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic [LANES*W-1:0]   v;
    logic [LANES*W-1:0]   b;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   r;
    logic [LANES-1:0]     overflow;

    modport master (
        output in_valid, in_mode, v, b, out_ready,
        input  in_ready, out_valid, r, overflow
    );

    modport slave (
        input  in_valid, in_mode, v, b, out_ready,
        output in_ready, out_valid, r, overflow
    );
endinterface

// File: rtl/vector_mul_pipe.sv
// Fully pipelined fixed-point vector multiplier (vector x scalar or element-wise),
// stall-all pipeline of LAT stages. Define VMUL_SATURATE_EN to clamp overflowing lanes.
module vector_mul_pipe #(
    parameter int LANES = 3,
    parameter int W     = 32,
    parameter int FRAC  = 16,
    parameter int LAT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    vector_mul_pipe_if.slave  bus
);
    localparam int VW = LANES * W;

    // Returns {overflow, result}; q is floor(p / 2^FRAC) thanks to the arithmetic shift.
    function automatic logic [W:0] lane_mul(input logic [W-1:0] a, input logic [W-1:0] c);
        logic signed [2*W-1:0] p;
        logic signed [2*W-1:0] q;
        logic                  ovf;
        logic [W-1:0]          res;
        p   = $signed({{W{a[W-1]}}, a}) * $signed({{W{c[W-1]}}, c});
        q   = p >>> FRAC;
        ovf = (q != {{W{q[W-1]}}, q[W-1:0]});
`ifdef VMUL_SATURATE_EN
        if (ovf) begin
            res = q[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            res = q[W-1:0];
        end
`else
        res = q[W-1:0];
`endif
        return {ovf, res};
    endfunction

    logic              stall_s;
    logic [VW-1:0]     op_b_d;
    logic [VW-1:0]     res_d;
    logic [LANES-1:0]  ovf_d;
    logic [W:0]        lane_s;

    logic [LAT-1:0]    vld_q;
    logic [VW-1:0]     op_v_q;
    logic [VW-1:0]     op_b_q;
    logic [VW-1:0]     res_q [1:LAT-1];
    logic [LANES-1:0]  ovf_q [1:LAT-1];

    assign stall_s       = vld_q[LAT-1] && !bus.out_ready;
    assign bus.in_ready  = !stall_s;
    assign bus.out_valid = vld_q[LAT-1];
    assign bus.r         = res_q[LAT-1];
    assign bus.overflow  = ovf_q[LAT-1];

    // Mode is resolved at capture: scalar mode broadcasts b lane 0 to every lane.
    always_comb begin
        op_b_d = bus.b;
        if (bus.in_mode == 1'b0) begin
            for (int k = 0; k < LANES; k++) begin
                op_b_d[W*k +: W] = bus.b[W-1:0];
            end
        end else begin
            op_b_d = bus.b;
        end
    end

    // Per-lane multiply, shift and range check on the captured operands.
    always_comb begin
        res_d  = '0;
        ovf_d  = '0;
        lane_s = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_s           = lane_mul(op_v_q[W*k +: W], op_b_q[W*k +: W]);
            res_d[W*k +: W]  = lane_s[W-1:0];
            ovf_d[k]         = lane_s[W];
        end
    end

    // Whole pipe advances together; a downstream stall freezes every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            op_v_q <= '0;
            op_b_q <= '0;
            for (int k = 1; k < LAT; k++) begin
                res_q[k] <= '0;
                ovf_q[k] <= '0;
            end
        end else if (!stall_s) begin
            vld_q    <= {vld_q[LAT-2:0], bus.in_valid};
            op_v_q   <= bus.v;
            op_b_q   <= op_b_d;
            res_q[1] <= res_d;
            ovf_q[1] <= ovf_d;
            for (int k = 2; k < LAT; k++) begin
                res_q[k] <= res_q[k-1];
                ovf_q[k] <= ovf_q[k-1];
            end
        end
    end
endmodule

// File: tb/tb_vector_mul_pipe.sv
// Self-checking bench for vector_mul_pipe: directed spec vectors, random streams
// with backpressure, and a mid-stream reset, scored against an arithmetic model.
module tb_vector_mul_pipe;
    localparam int LANES = 3;
    localparam int W     = 32;
    localparam int FRAC  = 16;
    localparam int LAT   = 4;
    localparam int VW    = LANES * W;
`ifdef VMUL_SATURATE_EN
    localparam bit          SAT   = 1'b1;
    localparam logic [31:0] OVP_R = 32'h7FFFFFFF;
    localparam logic [31:0] OVN_R = 32'h80000000;
`else
    localparam bit          SAT   = 1'b0;
    localparam logic [31:0] OVP_R = 32'hFFFE0000;
    localparam logic [31:0] OVN_R = 32'h00000000;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_mul_pipe_if #(.LANES(LANES), .W(W)) bus ();
    vector_mul_pipe #(.LANES(LANES), .W(W), .FRAC(FRAC), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [VW-1:0]    r;
        logic [LANES-1:0] ovf;
        int               acc_cyc;
        bit               chk_lat;
    } exp_t;

    exp_t             sb[$];
    int               n_vec = 0, n_mis = 0, cyc = 0, n_deliv = 0, n_notready = 0;
    bit               stall_prev = 1'b0;
    logic [VW-1:0]    prev_r;
    logic [LANES-1:0] prev_ovf;
    bit               use_dir = 1'b0, chk_lat = 1'b0;
    logic [VW-1:0]    dir_r;
    logic [LANES-1:0] dir_ovf;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed product, floor division by 2^FRAC, range test on the quotient.
    function automatic exp_t model(input logic [VW-1:0] v, input logic [VW-1:0] b, input logic mode);
        exp_t   e;
        longint a, c, q;
        e.r = '0; e.ovf = '0; e.acc_cyc = 0; e.chk_lat = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            a = longint'($signed(v[W*i +: W]));
            c = mode ? longint'($signed(b[W*i +: W])) : longint'($signed(b[W-1:0]));
            q = (a * c) >>> FRAC;
            e.ovf[i] = (q > 64'sd2147483647) || (q < -64'sd2147483648);
            if (e.ovf[i] && SAT) e.r[W*i +: W] = (q < 0) ? 32'h80000000 : 32'h7FFFFFFF;
            else                 e.r[W*i +: W] = q[31:0];
        end
        return e;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] x;
        logic [W-1:0]  w;
        for (int i = 0; i < LANES; i++) begin
            w = $urandom;
            x[W*i +: W] = W'($signed(w) >>> $urandom_range(0, 24));
        end
        return x;
    endfunction

    // One clock: observe handshakes mid-cycle, then advance to just after the next edge.
    task automatic tick(output bit acc);
        exp_t e;
        #1;
        acc = 1'b0;
        chk("in_ready", VW'(bus.in_ready), VW'(!(bus.out_valid && !bus.out_ready)));
        if (!bus.in_ready) n_notready++;
        if (stall_prev) begin
            chk("hold_r", bus.r, prev_r);
            chk("hold_ovf", VW'(bus.overflow), VW'(prev_ovf));
            chk("hold_valid", VW'(bus.out_valid), VW'(1));
        end
        if (bus.in_valid && bus.in_ready) begin
            e = model(bus.v, bus.b, bus.in_mode);
            if (use_dir) begin
                e.r   = dir_r;
                e.ovf = dir_ovf;
            end
            e.acc_cyc = cyc;
            e.chk_lat = chk_lat;
            sb.push_back(e);
            acc = 1'b1;
        end
        if (bus.out_valid && bus.out_ready) begin
            n_deliv++;
            if (sb.size() == 0) begin
                chk("spurious_out_valid", VW'(bus.out_valid), VW'(0));
            end else begin
                e = sb.pop_front();
                chk("result_r", bus.r, e.r);
                chk("result_ovf", VW'(bus.overflow), VW'(e.ovf));
                if (e.chk_lat) chk("latency", VW'(cyc - e.acc_cyc), VW'(LAT));
            end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        prev_r     = bus.r;
        prev_ovf   = bus.overflow;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [VW-1:0] v, input logic [VW-1:0] b, input logic mode);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        bus.in_valid = 1'b1; bus.v = v; bus.b = b; bus.in_mode = mode;
        while (!acc && n < 100) begin
            tick(acc);
            n++;
        end
        if (!acc) chk("accept_timeout", VW'(acc), VW'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic send_dir(input logic [VW-1:0] v, input logic [VW-1:0] b, input logic mode,
                            input logic [VW-1:0] r, input logic [LANES-1:0] ovf);
        use_dir = 1'b1; dir_r = r; dir_ovf = ovf;
        send(v, b, mode);
        use_dir = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            tick(acc);
            n++;
        end
        chk("drain_empty", VW'(sb.size()), VW'(0));
    endtask

    initial begin
        bit            acc;
        int            i, c, d0, nr0;
        logic [VW-1:0] tv [20];
        logic [VW-1:0] tbv[20];
        logic          tm [20];

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.v = '0; bus.b = '0; bus.out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("reset_out_valid", VW'(bus.out_valid), VW'(0));
        chk("reset_r", bus.r, VW'(0));
        chk("reset_ovf", VW'(bus.overflow), VW'(0));
        chk("reset_in_ready", VW'(bus.in_ready), VW'(1));

        // Directed vectors, back-to-back with mixed modes; latency checked.
        chk_lat = 1'b1;
        send_dir({32'hFFFF0000, 32'h00018000, 32'h00020000}, {32'h12345678, 32'h9ABCDEF0, 32'h00008000}, 1'b0,
                 {32'hFFFF8000, 32'h0000C000, 32'h00010000}, 3'b000);
        send_dir({32'h00010000, 32'h00030000, 32'h00020000}, {32'h00000000, 32'hFFFF0000, 32'h00018000}, 1'b1,
                 {32'h00000000, 32'hFFFD0000, 32'h00030000}, 3'b000);
        send_dir({32'h00000000, 32'h00000001, 32'hFFFFFFFF}, {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00008000}, 1'b0,
                 {32'h00000000, 32'h00000000, 32'hFFFFFFFF}, 3'b000);
        send_dir({32'h00000000, 32'h00000000, 32'h7FFF0000}, {32'h00000000, 32'h00000000, 32'h00020000}, 1'b0,
                 {32'h00000000, 32'h00000000, OVP_R}, 3'b001);
        send_dir({32'h00000000, 32'h00000000, 32'h80000000}, {32'h00000000, 32'h00000000, 32'h00020000}, 1'b0,
                 {32'h00000000, 32'h00000000, OVN_R}, 3'b001);
        send_dir({32'h00000000, 32'h80000000, 32'h7FFFFFFF}, {32'h00000000, 32'h00000000, 32'h00010000}, 1'b0,
                 {32'h00000000, 32'h80000000, 32'h7FFFFFFF}, 3'b000);
        drain();
        chk_lat = 1'b0;

        // Random stream with random downstream backpressure.
        i = 0; c = 0;
        while ((i < 40 || sb.size() > 0) && c < 500) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (i < 40) begin
                bus.in_valid = 1'b1; bus.v = rnd_vec(); bus.b = rnd_vec(); bus.in_mode = $urandom_range(0, 1);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick(acc);
            if (acc) i++;
            c++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        drain();

        // 20 back-to-back transactions, out_ready low on cycles 6..15.
        for (int k = 0; k < 20; k++) begin
            tv[k] = rnd_vec(); tbv[k] = rnd_vec(); tm[k] = $urandom_range(0, 1);
        end
        i = 0; c = 0; d0 = n_deliv; nr0 = n_notready;
        while ((i < 20 || sb.size() > 0) && c < 300) begin
            bus.out_ready = !(c >= 6 && c <= 15);
            if (i < 20) begin
                bus.in_valid = 1'b1; bus.v = tv[i]; bus.b = tbv[i]; bus.in_mode = tm[i];
            end else begin
                bus.in_valid = 1'b0;
            end
            tick(acc);
            if (acc) i++;
            c++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        chk("bp_count", VW'(n_deliv - d0), VW'(20));
        chk("bp_stall_cycles", VW'(n_notready - nr0), VW'(10));

        // Reset with three transactions in flight, the oldest stalled at the output.
        send_dir({3{32'h00010000}}, {3{32'h00010000}}, 1'b1, {3{32'h00010000}}, 3'b000);
        send_dir({3{32'h00010000}}, {3{32'h00010000}}, 1'b1, {3{32'h00010000}}, 3'b000);
        send_dir({3{32'h00010000}}, {3{32'h00010000}}, 1'b1, {3{32'h00010000}}, 3'b000);
        bus.out_ready = 1'b0;
        tick(acc);
        tick(acc);
        chk("pre_rst_out_valid", VW'(bus.out_valid), VW'(1));
        rst = 1'b1;
        #1;
        chk("rst_out_valid", VW'(bus.out_valid), VW'(0));
        chk("rst_r", bus.r, VW'(0));
        chk("rst_ovf", VW'(bus.overflow), VW'(0));
        chk("rst_in_ready", VW'(bus.in_ready), VW'(1));
        sb.delete();
        stall_prev = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) tick(acc);
        chk_lat = 1'b1;
        send_dir({32'h00000000, 32'h00018000, 32'h00020000}, {32'h00000000, 32'h00000000, 32'h00020000}, 1'b0,
                 {32'h00000000, 32'h00030000, 32'h00040000}, 3'b000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
